// File: rtl/pio_in_pkg.sv
// Shared register offsets, edge-type codes and the per-bit edge qualifier
// used by the PIO input responder and its debounce slices.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(input logic cur, input logic prev, input int edge_type);
    case (edge_type)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchroniser, 3-sample history taken on the shared
// tick, and the debounced flop that follows three agreeing samples.
module pio_debounce_bit (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic pin,
  output logic deb
);

  logic [1:0] sync_reg;
  logic [2:0] hist_reg, hist_next;
  logic       deb_reg, deb_next;

  always_comb begin
    hist_next = hist_reg;
    deb_next  = deb_reg;
    if (tick) begin
      hist_next = {hist_reg[1:0], sync_reg[1]};
      // Three agreeing samples span two tick periods, so shorter glitches never qualify.
      if ((&hist_next) && !deb_reg) begin
        deb_next = 1'b1;
      end else if (!(|hist_next) && deb_reg) begin
        deb_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
      hist_reg <= '0;
      deb_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      hist_reg <= hist_next;
      deb_reg  <= deb_next;
    end
  end

  assign deb = deb_reg;

endmodule

// File: rtl/pio_in_responder.sv
// Avalon-MM PIO input slave: debounced inputs, edge capture (W1C) and a masked
// level interrupt. Define PIO_IRQ_EN to build the MASK register and irq.
module pio_in_responder
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 22,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  output logic             irq
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] PRE_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    pre_reg, pre_next;
  logic             tick;
  logic [WIDTH-1:0] deb, deb_d_reg, edge_vec;
  logic [WIDTH-1:0] cap_reg, cap_next, clr_vec, mask_val;
  logic [31:0]      rd_mux, readdata_reg;
  logic             valid_reg, irq_reg, irq_next;
  logic             wr_cap;
  logic             unused_wdata;

  assign unused_wdata = ^avs_writedata;

  assign tick     = (pre_reg == PRE_MAX);
  assign pre_next = tick ? '0 : pre_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .pin     (pin_in[gi]),
        .deb     (deb[gi])
      );
      assign edge_vec[gi] = edge_hit(deb[gi], deb_d_reg[gi], EDGE_TYPE);
    end
  endgenerate

  assign wr_cap  = avs_write && (avs_address == ADDR_CAPTURE);
  assign clr_vec = wr_cap ? avs_writedata[WIDTH-1:0] : '0;
  // A fresh edge wins over a same-cycle clear of that bit.
  assign cap_next = (cap_reg & ~clr_vec) | edge_vec;

`ifdef PIO_IRQ_EN
  logic             wr_mask;
  logic [WIDTH-1:0] mask_reg;

  assign wr_mask = avs_write && (avs_address == ADDR_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_reg <= '0;
    end else if (wr_mask) begin
      mask_reg <= avs_writedata[WIDTH-1:0];
    end
  end

  assign mask_val = mask_reg;
  assign irq_next = |(cap_reg & mask_reg);
`else
  assign mask_val = '0;
  assign irq_next = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = deb;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = mask_val;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = cap_reg;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_reg      <= '0;
      deb_d_reg    <= '0;
      cap_reg      <= '0;
      readdata_reg <= '0;
      valid_reg    <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      pre_reg   <= pre_next;
      deb_d_reg <= deb;
      cap_reg   <= cap_next;
      valid_reg <= avs_read;
      irq_reg   <= irq_next;
      if (avs_read) begin
        readdata_reg <= rd_mux;
      end
    end
  end

  assign avs_readdata      = readdata_reg;
  assign avs_readdatavalid = valid_reg;
  assign irq               = irq_reg;

endmodule

// File: tb/tb_pio_in_responder.sv
// Scoreboarded random bench for pio_in_responder: reads push expected words,
// an independent monitor pops them on readdatavalid.
`timescale 1ns/1ps
module tb_pio_in_responder;
  import pio_in_pkg::*;

  localparam int W      = 22;
  localparam int D      = 4;
  localparam int ET     = 1;
  localparam int SETTLE = 3 * D + 6;
`ifdef PIO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] pin_in = '0;
  logic [1:0]   avs_address = '0;
  logic         avs_read = 1'b0;
  logic         avs_write = 1'b0;
  logic [31:0]  avs_writedata = '0;
  logic [31:0]  avs_readdata;
  logic         avs_readdatavalid;
  logic         irq;

  always #5 clk = ~clk;

  pio_in_responder #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pin_in            (pin_in),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq               (irq)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Reference model: settled register contents.
  logic [W-1:0] deb_m = '0;
  logic [W-1:0] cap_m = '0;
  logic [W-1:0] mask_m = '0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  function automatic logic [W-1:0] edges_of(input logic [W-1:0] prev, input logic [W-1:0] cur);
    case (ET)
      0:       return ~prev & cur;
      1:       return prev & ~cur;
      default: return prev ^ cur;
    endcase
  endfunction

  function automatic logic [31:0] reg_value(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 2'd0) v[W-1:0] = deb_m;
    if (a == 2'd1 && IRQ_ON) v[W-1:0] = mask_m;
    if (a == 2'd3) v[W-1:0] = cap_m;
    return v;
  endfunction

  function automatic logic irq_exp();
    return IRQ_ON & (|(cap_m & mask_m));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: 0x%08h (cycle %0d)", name, act, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (avs_readdatavalid) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_readdatavalid: got 1, want 0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("read_data", avs_readdata, e.data);
        check("read_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [1:0] a, input logic [31:0] d);
    if (a == 2'd1) mask_m = d[W-1:0];
    if (a == 2'd3) cap_m = cap_m & ~d[W-1:0];
  endtask

  task automatic do_read(input logic [1:0] a);
    avs_address = a;
    avs_read = 1'b1;
    sb_q.push_back('{data: reg_value(a), due: cyc + 1});
    step(1);
    avs_read = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    model_write(a, d);
    step(1);
    avs_write = 1'b0;
  endtask

  task automatic do_rw(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_read = 1'b1;
    avs_write = 1'b1;
    sb_q.push_back('{data: reg_value(a), due: cyc + 1});
    model_write(a, d);
    step(1);
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic set_pins(input logic [W-1:0] v, input int hold);
    pin_in = v;
    step(hold);
    cap_m = cap_m | edges_of(deb_m, v);
    deb_m = v;
  endtask

  task automatic glitch(input logic [W-1:0] g, input int len);
    pin_in = deb_m ^ g;
    step(len);
    pin_in = deb_m;
    step(SETTLE);
  endtask

  task automatic check_irq(input string name);
    check(name, {31'b0, irq}, {31'b0, irq_exp()});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int q, p1, s;

    step(3);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_valid", {31'b0, avs_readdatavalid}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;

    // Stable input, then a falling edge captured within 15 cycles.
    set_pins(22'h1, 30);
    do_read(ADDR_DATA);
    do_write(ADDR_MASK, 32'h1);
    step(1);
    check_irq("irq_mask_no_cap");
    set_pins(22'h0, 15);
    do_read(ADDR_CAPTURE);
    step(1);
    check_irq("irq_on_edge");

    // Short glitches on bit3.
    glitch(22'h8, 1);
    glitch(22'h8, 5);
    do_read(ADDR_DATA);
    do_read(ADDR_CAPTURE);

    // W1C landing on the same cycle as a new bit0 capture.
    set_pins(22'h1, SETTLE);
    q = cyc;
    pin_in = 22'h0;
    p1 = ((q + 3 + D - 1) / D) * D;
    s = p1 + 2 * D + 1;
    while (cyc < s - 1) step(1);
    do_write(ADDR_CAPTURE, 32'h1);
    cap_m = cap_m | edges_of(deb_m, 22'h0);
    deb_m = 22'h0;
    check_irq("irq_race_0");
    step(1);
    check_irq("irq_race_1");
    do_read(ADDR_CAPTURE);

    // Plain clear: irq drops two cycles after the write is issued.
    do_write(ADDR_CAPTURE, 32'h1);
    check("irq_hold_1cyc", {31'b0, irq}, {31'b0, IRQ_ON});
    step(1);
    check_irq("irq_clear_2cyc");

    // Mask off, reserved offset, DATA write ignored, MASK readback.
    set_pins(22'h1, SETTLE);
    set_pins(22'h0, SETTLE);
    do_write(ADDR_MASK, 32'h0);
    step(1);
    check_irq("irq_masked_off");
    do_read(2'd2);
    do_write(2'd2, 32'hFFFF_FFFF);
    do_read(2'd2);
    do_write(ADDR_DATA, 32'h003F_FFFF);
    do_read(ADDR_DATA);
    do_write(ADDR_MASK, 32'hF);
    do_read(ADDR_MASK);
    do_read(ADDR_CAPTURE);
    step(1);
    check_irq("irq_mask_f");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 7))
        0:       set_pins(W'($urandom), SETTLE);
        1:       glitch(W'($urandom) | W'(1), $urandom_range(1, 2 * D));
        2:       do_read(2'($urandom_range(0, 3)));
        3:       do_write(ADDR_MASK, $urandom);
        4:       do_write(ADDR_CAPTURE, $urandom);
        5:       do_rw(ADDR_CAPTURE, $urandom);
        6:       do_rw(2'($urandom_range(0, 3)), $urandom);
        default: do_write(2'($urandom_range(0, 3)), $urandom);
      endcase
      step(1);
      check_irq("irq_rand");
    end
    do_read(ADDR_DATA);
    do_read(ADDR_CAPTURE);

    // Reset asserted while a read is in flight.
    set_pins(W'($urandom) | W'(5), SETTLE);
    avs_address = ADDR_DATA;
    avs_read = 1'b1;
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    check("midrst_valid", {31'b0, avs_readdatavalid}, 32'h0);
    check("midrst_readdata", avs_readdata, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    step(2);
    check("midrst_valid_hold", {31'b0, avs_readdatavalid}, 32'h0);
    deb_m = '0;
    cap_m = '0;
    mask_m = '0;
    reset_n = 1'b1;
    do_read(ADDR_DATA);
    do_read(ADDR_MASK);
    do_read(ADDR_CAPTURE);
    set_pins(pin_in, SETTLE);
    do_read(ADDR_DATA);
    do_read(ADDR_CAPTURE);
    step(1);
    check_irq("irq_after_rst");

    step(4);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
